// File: rtl/debounce_pkg.sv
// Shared widths, scanner state encoding and event payload for the debounce bus scanner.
package debounce_pkg;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        CMP,
        PUSH,
        NEXT
    } scan_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] diff;
    } scan_evt_t;
endpackage

// File: rtl/debounce_evt_fifo.sv
// First-word fall-through event FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle.
module debounce_evt_fifo
    import debounce_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  scan_evt_t push_data,
    output logic      full,
    input  logic      pop,
    output logic      valid,
    output scan_evt_t head
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] wr_ptr_reg;
    logic [PTR_W:0] rd_ptr_reg;
    scan_evt_t      mem_reg [DEPTH];
    logic           do_push;
    logic           do_pop;

    // Extra pointer bit separates the full and empty cases when the indices match.
    assign valid   = (wr_ptr_reg != rd_ptr_reg);
    assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                     (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_reg[wr_ptr_reg[PTR_W-1:0]] <= push_data;
    end

    assign head = valid ? mem_reg[rd_ptr_reg[PTR_W-1:0]] : '0;
endmodule

// File: rtl/debounce_bus_scanner.sv
// Round-robin scanner for addressable debouncer chips on a shared bus, emitting change events.
// Optional DEBOUNCE_SCAN_IRQ_EN adds a registered irq output for pending, unaccepted events.
module debounce_bus_scanner
    import debounce_pkg::*;
#(
    parameter int NUM_CHIPS     = 8,
    parameter int SETTLE_CYCLES = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_en,
    output logic [ADDR_W-1:0] aBus,
    input  logic [DATA_W-1:0] dBus,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [ADDR_W-1:0] evt_addr,
    output logic [DATA_W-1:0] evt_data,
    output logic [DATA_W-1:0] evt_diff,
`ifdef DEBOUNCE_SCAN_IRQ_EN
    output logic              irq,
`endif
    output logic              busy
);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_CHIPS - 1);
    localparam logic [3:0]        SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    scan_state_t       state_reg;
    scan_state_t       state_next;
    logic [ADDR_W-1:0] cur_addr_reg;
    logic [ADDR_W-1:0] abus_reg;
    logic [3:0]        settle_cnt_reg;
    logic [DATA_W-1:0] sample_reg;
    logic [DATA_W-1:0] diff_reg;
    logic [DATA_W-1:0] shadow_reg [NUM_CHIPS];
    logic              prime_reg;
    logic              fifo_full;
    logic              fifo_push;
    logic              fifo_pop;
    scan_evt_t         push_evt;
    scan_evt_t         head_evt;

    assign fifo_pop = evt_valid && evt_ready;
    assign push_evt = {cur_addr_reg, sample_reg, diff_reg};

    always_comb begin
        state_next = state_reg;
        fifo_push  = 1'b0;
        case (state_reg)
            IDLE:    if (scan_en) state_next = DRIVE;
            DRIVE:   state_next = SETTLE;
            SETTLE:  if (settle_cnt_reg == '0) state_next = SAMPLE;
            SAMPLE:  state_next = CMP;
            CMP:     state_next = ((diff_reg != '0) && !prime_reg) ? PUSH : NEXT;
            // Hold the chip (and aBus) until the FIFO has room; a same-cycle pop frees a slot.
            PUSH: begin
                if (!fifo_full || fifo_pop) begin
                    fifo_push  = 1'b1;
                    state_next = NEXT;
                end
            end
            NEXT:    state_next = scan_en ? DRIVE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cur_addr_reg   <= '0;
            abus_reg       <= '0;
            settle_cnt_reg <= '0;
            sample_reg     <= '0;
            diff_reg       <= '0;
            prime_reg      <= 1'b1;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                DRIVE: begin
                    abus_reg       <= cur_addr_reg;
                    settle_cnt_reg <= SETTLE_LOAD;
                end
                SETTLE: if (settle_cnt_reg != '0) settle_cnt_reg <= settle_cnt_reg - 1'b1;
                SAMPLE: begin
                    sample_reg <= dBus;
                    diff_reg   <= dBus ^ shadow_reg[cur_addr_reg];
                end
                NEXT: begin
                    if (cur_addr_reg == LAST_ADDR) begin
                        cur_addr_reg <= '0;
                        prime_reg    <= 1'b0;
                    end else begin
                        cur_addr_reg <= cur_addr_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_CHIPS; gi++) begin : g_shadow
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                shadow_reg[gi] <= '0;
            else if (state_reg == CMP && cur_addr_reg == ADDR_W'(gi))
                shadow_reg[gi] <= sample_reg;
        end
    end

    debounce_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_evt),
        .full      (fifo_full),
        .pop       (fifo_pop),
        .valid     (evt_valid),
        .head      (head_evt)
    );

    assign aBus     = abus_reg;
    assign busy     = (state_reg != IDLE);
    assign evt_addr = head_evt.addr;
    assign evt_data = head_evt.data;
    assign evt_diff = head_evt.diff;

`ifdef DEBOUNCE_SCAN_IRQ_EN
    logic irq_reg;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_reg <= 1'b0;
        else     irq_reg <= evt_valid && !evt_ready;
    end
    assign irq = irq_reg;
`endif
endmodule
